lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/riscv_defines.sv | 39 +++
 rtl/lsu_align.sv | 59 +++++
 rtl/lsu_ctrl.sv | 148 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// Shared definitions for the load/store unit: access size codes, FSM states, request metadata.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package riscv_defines;

   // Access size encodings as driven on lsu_size_i
   localparam logic [1:0] LSU_BYTE = 2'b00;
   localparam logic [1:0] LSU_HALF = 2'b01;
   localparam logic [1:0] LSU_WORD = 2'b10;
   localparam logic [1:0] LSU_ILL  = 2'b11;

   // Controller states; anything other than IDLE means the pipeline must stall
   typedef enum logic [1:0] {
      IDLE        = 2'b00,
      REQ         = 2'b01,
      WAIT_RVALID = 2'b10
   } lsu_state_e;

   // Per-transaction attributes kept for the whole flight of a request
   typedef struct packed {
      logic       we;
      logic [1:0] size;
      logic       sext;
      logic [1:0] off;
   } lsu_meta_t;

   // True when the access cannot be issued: illegal size or natural-alignment violation
   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         LSU_BYTE: bad = 1'b0;
         LSU_HALF: bad = off[0];
         LSU_WORD: bad = |off;
         default:  bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store byte enables/lane shift and load extract + sign/zero extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs every cycle.
module lsu_align
   import riscv_defines::*;
#(
   parameter int WORD_WIDTH = 32
) (
   input  logic [1:0]            i_st_size,
   input  logic [1:0]            i_st_off,
   input  logic [WORD_WIDTH-1:0] i_st_wdata,
   output logic [3:0]            o_st_be,
   output logic [WORD_WIDTH-1:0] o_st_wdata,
   output logic                  o_st_err,
   input  logic [1:0]            i_ld_size,
   input  logic                  i_ld_sext,
   input  logic [1:0]            i_ld_off,
   input  logic [WORD_WIDTH-1:0] i_ld_rdata,
   output logic [WORD_WIDTH-1:0] o_ld_data
);

   logic [WORD_WIDTH-1:0] w_ld_shifted;
   logic                  w_ld_sign;

   assign o_st_err     = lsu_misaligned(i_st_size, i_st_off);
   // Store data is LSB-justified from the core; move it up to the addressed lane
   assign o_st_wdata   = i_st_wdata << {i_st_off, 3'b000};
   // Bring the addressed lane down to bit 0 before truncation
   assign w_ld_shifted = i_ld_rdata >> {i_ld_off, 3'b000};

   // Byte enables select exactly the lanes touched by the access
   always_comb begin
      o_st_be = 4'b0000;
      case (i_st_size)
         LSU_BYTE: o_st_be = 4'b0001 << i_st_off;
         LSU_HALF: o_st_be = i_st_off[1] ? 4'b1100 : 4'b0011;
         LSU_WORD: o_st_be = 4'b1111;
         default:  o_st_be = 4'b0000;
      endcase
   end

   // Truncate to access size, then replicate the top kept bit (signed) or zeros (unsigned)
   always_comb begin
      o_ld_data = w_ld_shifted;
      w_ld_sign = 1'b0;
      case (i_ld_size)
         LSU_BYTE: begin
            w_ld_sign = i_ld_sext & w_ld_shifted[7];
            o_ld_data = {{(WORD_WIDTH-8){w_ld_sign}}, w_ld_shifted[7:0]};
         end
         LSU_HALF: begin
            w_ld_sign = i_ld_sext & w_ld_shifted[15];
            o_ld_data = {{(WORD_WIDTH-16){w_ld_sign}}, w_ld_shifted[15:0]};
         end
         default: o_ld_data = w_ld_shifted;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one request from execute, drives a req/gnt/rvalid data-memory port.
// Latency: accept -> lsu_done_o in 3 cycles minimum; misaligned/illegal -> lsu_err_o the next cycle.
// Backpressure: lsu_busy_o stalls the pipeline; grant and rvalid may each be withheld indefinitely.
module lsu_ctrl
   import riscv_defines::*;
#(
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  lsu_req_i,
   input  logic                  lsu_we_i,
   input  logic [1:0]            lsu_size_i,
   input  logic                  lsu_sign_ext_i,
   input  logic [WORD_WIDTH-1:0] lsu_addr_i,
   input  logic [WORD_WIDTH-1:0] lsu_wdata_i,
   output logic                  lsu_busy_o,
   output logic                  lsu_done_o,
   output logic                  lsu_err_o,
   output logic [WORD_WIDTH-1:0] lsu_rdata_o,
   output logic                  data_req_o,
   output logic                  data_we_o,
   output logic [WORD_WIDTH-1:0] data_addr_o,
   output logic [WORD_WIDTH-1:0] data_wdata_o,
   output logic [3:0]            data_be_o,
   input  logic                  data_gnt_i,
   input  logic                  data_rvalid_i,
   input  logic [WORD_WIDTH-1:0] data_rdata_i
);

   lsu_state_e            r_state;
   lsu_state_e            w_state_nxt;
   lsu_meta_t             r_meta;
   logic [WORD_WIDTH-1:0] r_addr;
   logic [WORD_WIDTH-1:0] r_wdata;
   logic [3:0]            r_be;
   logic [WORD_WIDTH-1:0] r_rdata;
   logic                  r_done;
   logic                  r_err;

   logic                  w_accept;
   logic                  w_go_req;
   logic                  w_err_req;
   logic                  w_rsp;
   logic                  w_busy;
   logic                  w_data_req;
   logic [3:0]            w_st_be;
   logic [WORD_WIDTH-1:0] w_st_wdata;
   logic                  w_st_err;
   logic [WORD_WIDTH-1:0] w_ld_data;

   // Requests are only looked at in IDLE; a busy controller simply ignores them
   assign w_accept  = (r_state == IDLE) & lsu_req_i;
   assign w_go_req  = w_accept & ~w_st_err;
   assign w_err_req = w_accept &  w_st_err;
   // rvalid outside WAIT_RVALID is stray and must not complete anything
   assign w_rsp     = (r_state == WAIT_RVALID) & data_rvalid_i;

   lsu_align #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_align (
      .i_st_size  (lsu_size_i),
      .i_st_off   (lsu_addr_i[1:0]),
      .i_st_wdata (lsu_wdata_i),
      .o_st_be    (w_st_be),
      .o_st_wdata (w_st_wdata),
      .o_st_err   (w_st_err),
      .i_ld_size  (r_meta.size),
      .i_ld_sext  (r_meta.sext),
      .i_ld_off   (r_meta.off),
      .i_ld_rdata (data_rdata_i),
      .o_ld_data  (w_ld_data)
   );

   // State register; reset abandons any transaction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and state-decoded outputs
   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b1;
      w_data_req  = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (w_go_req) w_state_nxt = REQ;
         end
         REQ: begin
            w_data_req = 1'b1;
            if (data_gnt_i) w_state_nxt = WAIT_RVALID;
         end
         WAIT_RVALID: begin
            if (data_rvalid_i) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Capture the request on a legal accept; held unchanged until the next accept so the
   // memory-side address/be/wdata stay stable for the whole REQ phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= 4'b0000;
      end else if (w_go_req) begin
         r_meta.we   <= lsu_we_i;
         r_meta.size <= lsu_size_i;
         r_meta.sext <= lsu_sign_ext_i;
         r_meta.off  <= lsu_addr_i[1:0];
         r_addr      <= {lsu_addr_i[WORD_WIDTH-1:2], 2'b00};
         r_wdata     <= w_st_wdata;
         r_be        <= w_st_be;
      end
   end

   // One-cycle completion and error pulses; they come from disjoint states so never overlap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_done <= w_rsp;
         r_err  <= w_err_req;
      end
   end

   // Load result is updated only when a load completes; stores leave it untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    r_rdata <= '0;
      else if (w_rsp && !r_meta.we)  r_rdata <= w_ld_data;
   end

   assign lsu_busy_o   = w_busy;
   assign lsu_done_o   = r_done;
   assign lsu_err_o    = r_err;
   assign lsu_rdata_o  = r_rdata;
   assign data_req_o   = w_data_req;
   assign data_we_o    = r_meta.we;
   assign data_addr_o  = r_addr;
   assign data_wdata_o = r_wdata;
   assign data_be_o    = r_be;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed transactions against a byte-lane transaction model plus literal checks.
// Latency: measured per transaction from the cycle the request is presented.
// Backpressure: grant and rvalid delays are driven per transaction.
module tb_lsu_ctrl;
   import riscv_defines::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
   logic [1:0]  lsu_size_i;
   logic [31:0] lsu_addr_i, lsu_wdata_i;
   logic        lsu_busy_o, lsu_done_o, lsu_err_o;
   logic [31:0] lsu_rdata_o;
   logic        data_req_o, data_we_o;
   logic [31:0] data_addr_o, data_wdata_o;
   logic [3:0]  data_be_o;
   logic        data_gnt_i, data_rvalid_i;
   logic [31:0] data_rdata_i;

   always #5 clk = ~clk;

   lsu_ctrl #(.WORD_WIDTH(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .lsu_req_i      (lsu_req_i),
      .lsu_we_i       (lsu_we_i),
      .lsu_size_i     (lsu_size_i),
      .lsu_sign_ext_i (lsu_sign_ext_i),
      .lsu_addr_i     (lsu_addr_i),
      .lsu_wdata_i    (lsu_wdata_i),
      .lsu_busy_o     (lsu_busy_o),
      .lsu_done_o     (lsu_done_o),
      .lsu_err_o      (lsu_err_o),
      .lsu_rdata_o    (lsu_rdata_o),
      .data_req_o     (data_req_o),
      .data_we_o      (data_we_o),
      .data_addr_o    (data_addr_o),
      .data_wdata_o   (data_wdata_o),
      .data_be_o      (data_be_o),
      .data_gnt_i     (data_gnt_i),
      .data_rvalid_i  (data_rvalid_i),
      .data_rdata_i   (data_rdata_i)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int done_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected transaction, computed from byte-lane rules
   typedef struct {
      logic        err;
      logic        we;
      logic [31:0] addr_w;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   logic [31:0] m_rdata = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   function automatic int nbytes(input logic [1:0] size);
      case (size)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
      int n   = nbytes(size);
      int off = int'(addr[1:0]);
      if (n == 0) return 1'b1;
      return (off % n) != 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
      logic [3:0] be = 4'b0000;
      int n   = nbytes(size);
      int off = int'(addr[1:0]);
      for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] wdata, input logic [31:0] addr);
      logic [31:0] r = 32'h0;
      int off = int'(addr[1:0]);
      for (int i = 0; i < 4; i++)
         if (i >= off) r[8*i +: 8] = wdata[8*(i-off) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] size,
                                              input logic sext, input logic [31:0] addr);
      logic [31:0] v = 32'h0;
      int n   = nbytes(size);
      int off = int'(addr[1:0]);
      for (int k = 0; k < n; k++)
         if (off + k < 4) v[8*k +: 8] = rdata[8*(off+k) +: 8];
      if (sext && n > 0 && n < 4 && v[8*n-1])
         for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
      return v;
   endfunction

   // Compare process: every cycle out of reset, DUT outputs against the transaction model
   always @(negedge clk) begin
      if (rst_n) begin
         check("done_err_exclusive", 32'(lsu_done_o & lsu_err_o), 32'h0);
         if (data_req_o) begin
            tests++;
            if (exp_q.size() == 0 || exp_q[0].err) begin
               fails++;
               $display("FAIL req_unexpected: data_req_o=1, expected no memory request (t=%0t)", $time);
            end else begin
               check("req_addr",  data_addr_o,       exp_q[0].addr_w);
               check("req_be",    32'(data_be_o),    32'(exp_q[0].be));
               check("req_we",    32'(data_we_o),    32'(exp_q[0].we));
               check("req_wdata", data_wdata_o,      exp_q[0].wdata);
            end
         end
         if (lsu_done_o) begin
            done_cnt++;
            tests++;
            if (exp_q.size() == 0 || exp_q[0].err) begin
               fails++;
               $display("FAIL done_unexpected: lsu_done_o=1, expected no completion (t=%0t)", $time);
            end else begin
               cur = exp_q.pop_front();
               if (!cur.we) m_rdata = cur.rdata;
            end
         end
         if (lsu_err_o) begin
            tests++;
            if (exp_q.size() == 0 || !exp_q[0].err) begin
               fails++;
               $display("FAIL err_unexpected: lsu_err_o=1, expected no error (t=%0t)", $time);
            end else begin
               cur = exp_q.pop_front();
            end
         end
         check("rdata_hold", lsu_rdata_o, m_rdata);
      end
   end

   // Push the model's view of a request and present it on the LSU port
   task automatic present(input logic we, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
      exp_t e;
      e.err    = model_err(size, addr);
      e.we     = we;
      e.addr_w = {addr[31:2], 2'b00};
      e.be     = model_be(size, addr);
      e.wdata  = model_wdata(wdata, addr);
      e.rdata  = model_load(rdata, size, sext, addr);
      exp_q.push_back(e);
      lsu_req_i      = 1'b1;
      lsu_we_i       = we;
      lsu_size_i     = size;
      lsu_sign_ext_i = sext;
      lsu_addr_i     = addr;
      lsu_wdata_i    = wdata;
   endtask

   // One complete transaction; called and returns just after a rising edge
   task automatic run_op(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input int gnt_wait, input int rv_wait, input logic stray,
                         output int lat, output int req_cycles,
                         output logic [31:0] c_addr, output logic [3:0] c_be, output logic [31:0] c_wdata);
      int c0;
      int n;
      lat = -1; req_cycles = 0; c_addr = 32'h0; c_be = 4'h0; c_wdata = 32'h0;
      present(we, size, sext, addr, wdata, rdata);
      c0 = cyc;
      @(posedge clk); #1;
      lsu_req_i = 1'b0;
      if (model_err(size, addr)) begin
         @(negedge clk);
         check("err_pulse",  32'(lsu_err_o),  32'h1);
         check("err_busy",   32'(lsu_busy_o), 32'h0);
         check("err_no_req", 32'(data_req_o), 32'h0);
         @(posedge clk); #1;
         @(negedge clk);
         check("err_one_cycle", 32'(lsu_err_o),  32'h0);
         check("err_busy2",     32'(lsu_busy_o), 32'h0);
         @(posedge clk); #1;
         return;
      end
      @(negedge clk);
      check("busy_in_req", 32'(lsu_busy_o), 32'h1);
      c_addr = data_addr_o; c_be = data_be_o; c_wdata = data_wdata_o;
      for (int k = 0; k <= gnt_wait; k++) begin
         if (data_req_o) req_cycles++;
         data_gnt_i    = (k == gnt_wait);
         data_rvalid_i = stray && (k < gnt_wait);
         if (stray) begin
            lsu_req_i  = (k < gnt_wait);
            lsu_we_i   = 1'b0;
            lsu_size_i = LSU_WORD;
            lsu_addr_i = 32'h0000_0300;
         end
         @(posedge clk); #1;
         data_gnt_i = 1'b0; data_rvalid_i = 1'b0; lsu_req_i = 1'b0;
         @(negedge clk);
      end
      check("req_drop_after_gnt", 32'(data_req_o), 32'h0);
      for (int k = 0; k <= rv_wait; k++) begin
         data_rvalid_i = (k == rv_wait);
         data_rdata_i  = (k == rv_wait) ? rdata : 32'hA5A5_5A5A;
         @(posedge clk); #1;
         data_rvalid_i = 1'b0;
         @(negedge clk);
      end
      n = 0;
      while (!lsu_done_o && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (lsu_done_o) lat = cyc - c0;
      @(posedge clk); #1;
   endtask

   int          lat, rq, dc;
   logic [31:0] ca, cw;
   logic [3:0]  cb;

   initial begin
      rst_n = 1'b0;
      lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00; lsu_sign_ext_i = 1'b0;
      lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy",  32'(lsu_busy_o), 32'h0);
      check("rst_req",   32'(data_req_o), 32'h0);
      check("rst_we",    32'(data_we_o),  32'h0);
      check("rst_done",  32'(lsu_done_o), 32'h0);
      check("rst_err",   32'(lsu_err_o),  32'h0);
      check("rst_be",    32'(data_be_o),  32'h0);
      check("rst_addr",  data_addr_o,     32'h0);
      check("rst_wdata", data_wdata_o,    32'h0);
      check("rst_rdata", lsu_rdata_o,     32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Word store, fastest handshake
      run_op(1'b1, LSU_WORD, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, lat, rq, ca, cb, cw);
      check("sw_be",    32'(cb), 32'hF);
      check("sw_addr",  ca,      32'h100);
      check("sw_wdata", cw,      32'hDEAD_BEEF);
      check("sw_lat",   32'(lat), 32'd3);
      check("sw_reqcyc", 32'(rq), 32'd1);

      // Signed and unsigned byte loads from the top lane
      run_op(1'b0, LSU_BYTE, 1'b1, 32'h203, 32'h0, 32'h80FF_0011, 0, 0, 1'b0, lat, rq, ca, cb, cw);
      check("lbs_be",    32'(cb),    32'h8);
      check("lbs_addr",  ca,         32'h200);
      check("lbs_rdata", lsu_rdata_o, 32'hFFFF_FF80);
      run_op(1'b0, LSU_BYTE, 1'b0, 32'h203, 32'h0, 32'h80FF_0011, 0, 0, 1'b0, lat, rq, ca, cb, cw);
      check("lbu_rdata", lsu_rdata_o, 32'h0000_0080);

      // Half store with grant withheld four cycles
      run_op(1'b1, LSU_HALF, 1'b0, 32'h102, 32'h0000_ABCD, 32'h0, 4, 0, 1'b0, lat, rq, ca, cb, cw);
      check("sh_reqcyc", 32'(rq),  32'd5);
      check("sh_be",     32'(cb),  32'hC);
      check("sh_wdata",  cw,       32'hABCD_0000);
      check("sh_addr",   ca,       32'h100);
      check("sh_lat",    32'(lat), 32'd7);
      check("sh_rdata_kept", lsu_rdata_o, 32'h0000_0080);

      // Misaligned word and illegal size
      run_op(1'b0, LSU_WORD, 1'b0, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0, lat, rq, ca, cb, cw);
      run_op(1'b0, LSU_ILL,  1'b0, 32'h100, 32'h0, 32'h0, 0, 0, 1'b0, lat, rq, ca, cb, cw);
      run_op(1'b1, LSU_HALF, 1'b0, 32'h103, 32'h1, 32'h0, 0, 0, 1'b0, lat, rq, ca, cb, cw);

      // Byte store to lane 1 and unsigned half load from lane 0
      run_op(1'b1, LSU_BYTE, 1'b0, 32'h001, 32'h1234_5678, 32'h0, 0, 0, 1'b0, lat, rq, ca, cb, cw);
      check("sb_be",    32'(cb), 32'h2);
      check("sb_wdata", cw,      32'h3456_7800);
      run_op(1'b0, LSU_HALF, 1'b0, 32'h000, 32'h0, 32'h1234_F00D, 0, 2, 1'b0, lat, rq, ca, cb, cw);
      check("lhu_rdata", lsu_rdata_o, 32'h0000_F00D);
      check("lhu_lat",   32'(lat),    32'd5);

      // Stray rvalid in REQ and a second request while busy
      dc = done_cnt;
      run_op(1'b0, LSU_HALF, 1'b1, 32'h206, 32'h0, 32'h8001_1234, 2, 1, 1'b1, lat, rq, ca, cb, cw);
      repeat (4) @(posedge clk);
      #1;
      check("stray_rdata",  lsu_rdata_o,        32'hFFFF_8001);
      check("stray_lat",    32'(lat),           32'd6);
      check("stray_dones",  32'(done_cnt - dc), 32'd1);

      // Reset while waiting for rvalid
      present(1'b0, LSU_WORD, 1'b0, 32'h400, 32'h0, 32'h1111_2222);
      @(posedge clk); #1;
      lsu_req_i = 1'b0;
      data_gnt_i = 1'b1;
      @(posedge clk); #1;
      data_gnt_i = 1'b0;
      @(negedge clk);
      check("pre_rst_busy", 32'(lsu_busy_o), 32'h1);
      check("pre_rst_req",  32'(data_req_o), 32'h0);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      m_rdata = 32'h0;
      #1;
      check("mid_rst_busy",  32'(lsu_busy_o), 32'h0);
      check("mid_rst_req",   32'(data_req_o), 32'h0);
      check("mid_rst_we",    32'(data_we_o),  32'h0);
      check("mid_rst_be",    32'(data_be_o),  32'h0);
      check("mid_rst_addr",  data_addr_o,     32'h0);
      check("mid_rst_wdata", data_wdata_o,    32'h0);
      check("mid_rst_rdata", lsu_rdata_o,     32'h0);
      dc = done_cnt;
      @(posedge clk); #1;
      rst_n = 1'b1;
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'h1111_2222;
      @(posedge clk); #1;
      data_rvalid_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("post_rst_dones", 32'(done_cnt - dc), 32'd0);
      check("post_rst_busy",  32'(lsu_busy_o),    32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
